// File: rtl/portal_pkg.sv
// Purpose : shared types, field widths and helpers for the portal request path.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   CHAN_W / METH_W / WORD_W  field widths of a queued call and of a pipe word
//   HDR_CHAN_LSB              bit position of the channel number in a header word
//   PORTAL_DATA_W             payload width of the reference build
//   portal_msg_t              {chan, meth, v} message at the reference width
//   words_per_msg()           pipe words needed for one message of a given width
package portal_pkg;

   // Channel numbers are carried in 4 bits, enough for the 16-channel maximum.
   localparam int CHAN_W        = 4;
   localparam int METH_W        = 32;
   localparam int WORD_W        = 32;
   localparam int HDR_CHAN_LSB  = 16;
   localparam int PORTAL_DATA_W = 64;

   // Reference message layout. Blocks built at another payload width declare
   // the same field order locally with their own DATA_W.
   typedef struct packed {
      logic [CHAN_W-1:0]        chan;
      logic [METH_W-1:0]        meth;
      logic [PORTAL_DATA_W-1:0] v;
   } portal_msg_t;

   // One header word, one method word, then the payload split into 32-bit words.
   function automatic int words_per_msg(input int data_w);
      return 2 + data_w / WORD_W;
   endfunction

endpackage

// File: rtl/portal_msg_fifo.sv
// Purpose : synchronous show-ahead FIFO holding whole portal messages.
// Latency : pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_dat    write one entry at the tail
//   pop, pop_dat      head entry (combinational read) and its removal strobe
//   full, empty       status from the registered count
//   count             number of stored entries (0..DEPTH)
module portal_msg_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/portal_request_mux.sv
// Purpose : N-channel method-call marshaller: per-channel slots, round-robin
//           arbiter into a message FIFO, serializer onto one 32-bit pipe.
// Latency : call at cycle 0 -> slot valid cycle 1 -> header on pipe cycle 2.
// Backpressure: pipe_enq__RDY low freezes the current word; a full FIFO
//           stops grants so slots hold and their say__RDY stays low.
//
// Ports:
//   CLK, nRST                   clock, synchronous active-high reset
//   say__ENA/say_meth/say_v     per-channel call (channel i at slice i)
//   say__RDY                    per-channel slot empty
//   pipe_enq__ENA/_v/__RDY      serialized word output, transfer = ENA && RDY
//   fifo_count                  messages waiting in the FIFO
//   msg_count                   fully emitted messages, free-running 32 bit
module portal_request_mux
   import portal_pkg::*;
#(
   parameter int NCHAN  = 4,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NCHAN-1:0]          say__ENA,
   input  logic [NCHAN*32-1:0]       say_meth,
   input  logic [NCHAN*DATA_W-1:0]   say_v,
   output logic [NCHAN-1:0]          say__RDY,
   output logic                      pipe_enq__ENA,
   output logic [31:0]               pipe_enq_v,
   input  logic                      pipe_enq__RDY,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [31:0]               msg_count
);

   localparam int NW     = words_per_msg(DATA_W);
   localparam int PW     = DATA_W / WORD_W;
   localparam int WIDX_W = $clog2(NW);

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      logic [METH_W-1:0] meth;
      logic [DATA_W-1:0] v;
   } msg_t;

   localparam int MSG_W = $bits(msg_t);

   // ------------------------------------------------------------------
   // Per-channel one-entry slots
   // ------------------------------------------------------------------
   logic [NCHAN-1:0]  slot_valid;
   logic [METH_W-1:0] slot_meth [NCHAN];
   logic [DATA_W-1:0] slot_v    [NCHAN];
   logic [NCHAN-1:0]  capture;

   // Arbiter
   logic [CHAN_W-1:0] rr_ptr;
   logic              grant_vld;
   logic [CHAN_W-1:0] grant_idx;
   logic              hi_found;
   logic              lo_found;
   logic [CHAN_W-1:0] hi_idx;
   logic [CHAN_W-1:0] lo_idx;

   // FIFO
   msg_t              push_msg;
   msg_t              head_msg;
   logic [MSG_W-1:0]  head_raw;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   // Serializer
   logic [WIDX_W-1:0] word_idx;
   logic              xfer;
   logic              last_word;
   logic [31:0]       hdr_word;

   // Ready is the registered slot state, forced low while reset is applied
   // so no call can be presented against stale state.
   assign say__RDY = ~slot_valid & {NCHAN{~nRST}};
   assign capture  = say__ENA & say__RDY;

   always_ff @(posedge CLK) begin
      if (nRST) begin
         slot_valid <= '0;
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            // Capture needs an empty slot and grant needs a full one, so the
            // two never hit the same slot in one cycle.
            if (capture[i]) begin
               slot_valid[i] <= 1'b1;
            end else if (grant_vld && (grant_idx == CHAN_W'(i))) begin
               slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NCHAN; i++) begin
         if (capture[i]) begin
            slot_meth[i] <= say_meth[32*i +: 32];
            slot_v[i]    <= say_v[DATA_W*i +: DATA_W];
         end
      end
   end

   // Calls into an occupied slot are dropped by the capture gating above;
   // flag them in simulation since they mean a broken upstream handshake.
   a_call_into_busy_slot: assert property (
      @(posedge CLK) disable iff (nRST) ((say__ENA & slot_valid) == '0)
   );

   // ------------------------------------------------------------------
   // Round-robin arbiter: lowest valid slot at or above rr_ptr, otherwise
   // wrap to the lowest valid slot overall.
   // ------------------------------------------------------------------
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (slot_valid[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = CHAN_W'(i);
         end
         if (slot_valid[i] && !hi_found && (CHAN_W'(i) >= rr_ptr)) begin
            hi_found = 1'b1;
            hi_idx   = CHAN_W'(i);
         end
      end
   end

   // Full comes from the registered count: a pop in this cycle does not
   // make room for a grant in the same cycle.
   assign grant_vld = (hi_found | lo_found) & ~fifo_full;
   assign grant_idx = hi_found ? hi_idx : lo_idx;

   always_ff @(posedge CLK) begin
      if (nRST) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= (grant_idx == CHAN_W'(NCHAN-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_comb begin
      push_msg      = '0;
      push_msg.chan = grant_idx;
      for (int i = 0; i < NCHAN; i++) begin
         if (grant_idx == CHAN_W'(i)) begin
            push_msg.meth = slot_meth[i];
            push_msg.v    = slot_v[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Message FIFO
   // ------------------------------------------------------------------
   portal_msg_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (MSG_W)
   ) u_fifo (
      .clk      (CLK),
      .rst      (nRST),
      .push     (grant_vld),
      .push_dat (push_msg),
      .pop      (fifo_pop),
      .pop_dat  (head_raw),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign head_msg = msg_t'(head_raw);

   // ------------------------------------------------------------------
   // Serializer: header, method, then payload least-significant word first.
   // ------------------------------------------------------------------
   assign pipe_enq__ENA = ~fifo_empty & ~nRST;
   assign xfer          = pipe_enq__ENA & pipe_enq__RDY;
   assign last_word     = (word_idx == WIDX_W'(NW-1));
   assign fifo_pop      = xfer & last_word;

   always_comb begin
      hdr_word                         = '0;
      hdr_word[HDR_CHAN_LSB +: 16]     = 16'(head_msg.chan);
      hdr_word[HDR_CHAN_LSB-1:0]       = 16'(PW);
   end

   always_comb begin
      pipe_enq_v = hdr_word;
      if (word_idx == WIDX_W'(1)) begin
         pipe_enq_v = head_msg.meth;
      end
      for (int k = 0; k < PW; k++) begin
         if (word_idx == WIDX_W'(k + 2)) begin
            pipe_enq_v = head_msg.v[WORD_W*k +: WORD_W];
         end
      end
   end

   // A reset mid-message drops word_idx back to 0 and empties the FIFO, so
   // the partial message is simply abandoned.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         word_idx  <= '0;
         msg_count <= '0;
      end else if (xfer) begin
         if (last_word) begin
            word_idx  <= '0;
            msg_count <= msg_count + 32'd1;
         end else begin
            word_idx  <= word_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_portal_request_mux.sv
module tb_portal_request_mux;

   logic          CLK = 1'b0;
   logic          nRST;

   // Main DUT: NCHAN=4, DATA_W=64, DEPTH=4
   logic [3:0]    say__ENA;
   logic [127:0]  say_meth;
   logic [255:0]  say_v;
   logic [3:0]    say__RDY;
   logic          pipe_enq__ENA;
   logic [31:0]   pipe_enq_v;
   logic          pipe_enq__RDY;
   logic [2:0]    fifo_count;
   logic [31:0]   msg_count;

   // Narrow DUT: NCHAN=1, DATA_W=32
   logic          a_ena;
   logic [31:0]   a_meth;
   logic [31:0]   a_v;
   logic          a_rdy;
   logic          a_pena;
   logic [31:0]   a_pv;
   logic          a_prdy;
   logic [2:0]    a_fcnt;
   logic [31:0]   a_mcnt;

   // Wide DUT: NCHAN=1, DATA_W=128
   logic          b_ena;
   logic [31:0]   b_meth;
   logic [127:0]  b_v;
   logic          b_rdy;
   logic          b_pena;
   logic [31:0]   b_pv;
   logic          b_prdy;
   logic [2:0]    b_fcnt;
   logic [31:0]   b_mcnt;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;

   logic [31:0]   got_q[$];
   int            got_cyc_q[$];
   logic [31:0]   exp_q[$];
   logic [31:0]   got_a_q[$];
   logic [31:0]   got_b_q[$];

   portal_request_mux #(.NCHAN(4), .DATA_W(64), .DEPTH(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
      .pipe_enq__ENA(pipe_enq__ENA), .pipe_enq_v(pipe_enq_v), .pipe_enq__RDY(pipe_enq__RDY),
      .fifo_count(fifo_count), .msg_count(msg_count)
   );

   portal_request_mux #(.NCHAN(1), .DATA_W(32), .DEPTH(4)) dut_a (
      .CLK(CLK), .nRST(nRST),
      .say__ENA(a_ena), .say_meth(a_meth), .say_v(a_v), .say__RDY(a_rdy),
      .pipe_enq__ENA(a_pena), .pipe_enq_v(a_pv), .pipe_enq__RDY(a_prdy),
      .fifo_count(a_fcnt), .msg_count(a_mcnt)
   );

   portal_request_mux #(.NCHAN(1), .DATA_W(128), .DEPTH(4)) dut_b (
      .CLK(CLK), .nRST(nRST),
      .say__ENA(b_ena), .say_meth(b_meth), .say_v(b_v), .say__RDY(b_rdy),
      .pipe_enq__ENA(b_pena), .pipe_enq_v(b_pv), .pipe_enq__RDY(b_prdy),
      .fifo_count(b_fcnt), .msg_count(b_mcnt)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Words are recorded at the falling edge; they transfer on the next rise.
   always @(negedge CLK) begin
      if (pipe_enq__ENA && pipe_enq__RDY) begin
         got_q.push_back(pipe_enq_v);
         got_cyc_q.push_back(cyc);
      end
      if (a_pena && a_prdy) got_a_q.push_back(a_pv);
      if (b_pena && b_prdy) got_b_q.push_back(b_pv);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got time %0t want < 400000", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST     = 1'b1;
      say__ENA = '0;
      a_ena    = 1'b0;
      b_ena    = 1'b0;
      repeat (3) step();
      nRST = 1'b0;
      got_q.delete();
      got_cyc_q.delete();
      exp_q.delete();
      got_a_q.delete();
      got_b_q.delete();
   endtask

   // Expected words of one 64-bit message, built from the header layout.
   function automatic void add_exp(input int ch, input logic [31:0] meth, input logic [63:0] v);
      logic [15:0] c16;
      c16 = 16'(ch);
      exp_q.push_back({c16, 16'd2});
      exp_q.push_back(meth);
      exp_q.push_back(v[31:0]);
      exp_q.push_back(v[63:32]);
   endfunction

   function automatic void load_call(input int ch, input logic [31:0] meth, input logic [63:0] v);
      say_meth[32*ch +: 32] = meth;
      say_v[64*ch +: 64]    = v;
   endfunction

   task automatic test_reset();
      nRST          = 1'b1;
      say__ENA      = '0;
      say_meth      = '0;
      say_v         = '0;
      pipe_enq__RDY = 1'b1;
      a_ena = 1'b0; a_meth = '0; a_v = '0; a_prdy = 1'b1;
      b_ena = 1'b0; b_meth = '0; b_v = '0; b_prdy = 1'b1;
      repeat (3) step();
      @(negedge CLK);
      n_vec++; if (say__RDY !== 4'h0) begin n_err++; $display("FAIL reset_rdy: got %h want 0", say__RDY); end
      n_vec++; if (pipe_enq__ENA !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", pipe_enq__ENA); end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
      n_vec++; if (msg_count !== 32'd0) begin n_err++; $display("FAIL reset_msg_count: got %0d want 0", msg_count); end
      step();
      nRST = 1'b0;
      @(negedge CLK);
      n_vec++; if (say__RDY !== 4'hF) begin n_err++; $display("FAIL reset_release_rdy: got %h want f", say__RDY); end
      n_vec++; if (pipe_enq__ENA !== 1'b0) begin n_err++; $display("FAIL reset_release_ena: got %b want 0", pipe_enq__ENA); end
   endtask

   task automatic test_single();
      logic [31:0] e [4];
      int c0;
      e = '{32'h0002_0002, 32'h0000_0005, 32'h3333_4444, 32'h1111_2222};
      do_reset();
      pipe_enq__RDY = 1'b1;
      load_call(2, 32'h5, 64'h1111_2222_3333_4444);
      say__ENA = 4'b0100;
      c0 = cyc;
      step();
      say__ENA = '0;
      repeat (8) step();
      n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL single_len: got %0d words want 4", got_q.size()); end
      for (int j = 0; j < 4 && j < got_q.size(); j++) begin
         n_vec++; if (got_q[j] !== e[j]) begin n_err++; $display("FAIL single_word%0d: got %h want %h", j, got_q[j], e[j]); end
         n_vec++; if (got_cyc_q[j] !== c0 + 2 + j) begin n_err++; $display("FAIL single_cycle%0d: got %0d want %0d", j, got_cyc_q[j] - c0, 2 + j); end
      end
      n_vec++; if (msg_count !== 32'd1) begin n_err++; $display("FAIL single_msg_count: got %0d want 1", msg_count); end
   endtask

   task automatic test_round_robin();
      int t;
      int order [6];
      order = '{0, 1, 2, 3, 0, 3};
      do_reset();
      pipe_enq__RDY = 1'b1;
      for (int ch = 0; ch < 4; ch++) begin
         load_call(ch, 32'h100 + 32'(ch), {32'hA000_0000 + 32'(ch), 32'hB000_0000 + 32'(ch)});
      end
      for (int ch = 0; ch < 4; ch++) add_exp(ch, 32'h100 + 32'(ch), {32'hA000_0000 + 32'(ch), 32'hB000_0000 + 32'(ch)});
      say__ENA = 4'hF;
      step();
      say__ENA = '0;
      t = 0;
      while (msg_count !== 32'd4 && t < 200) begin step(); t++; end
      n_vec++; if (msg_count !== 32'd4) begin n_err++; $display("FAIL rr_first_drain: got %0d want 4", msg_count); end
      // Channel 3 is named first in the call but rr_ptr wrapped to 0.
      load_call(3, 32'h203, 64'hC3C3_C3C3_D3D3_D3D3);
      load_call(0, 32'h200, 64'hC0C0_C0C0_D0D0_D0D0);
      add_exp(0, 32'h200, 64'hC0C0_C0C0_D0D0_D0D0);
      add_exp(3, 32'h203, 64'hC3C3_C3C3_D3D3_D3D3);
      say__ENA = 4'b1001;
      step();
      say__ENA = '0;
      t = 0;
      while (msg_count !== 32'd6 && t < 200) begin step(); t++; end
      n_vec++; if (msg_count !== 32'd6) begin n_err++; $display("FAIL rr_second_drain: got %0d want 6", msg_count); end
      n_vec++; if (got_q.size() !== 24) begin n_err++; $display("FAIL rr_len: got %0d words want 24", got_q.size()); end
      for (int m = 0; m < 6 && 4*m < got_q.size(); m++) begin
         n_vec++; if (got_q[4*m][31:16] !== 16'(order[m])) begin n_err++; $display("FAIL rr_order%0d: got chan %0d want %0d", m, got_q[4*m][31:16], order[m]); end
      end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_vec++; if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL rr_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_full();
      int t;
      do_reset();
      pipe_enq__RDY = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
         load_call(ch, 32'h300 + 32'(ch), {32'h1000_0000 + 32'(ch), 32'h2000_0000 + 32'(ch)});
         add_exp(ch, 32'h300 + 32'(ch), {32'h1000_0000 + 32'(ch), 32'h2000_0000 + 32'(ch)});
      end
      say__ENA = 4'hF;
      step();
      say__ENA = '0;
      repeat (5) step();
      @(negedge CLK);
      n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count_first: got %0d want 4", fifo_count); end
      n_vec++; if (say__RDY !== 4'hF) begin n_err++; $display("FAIL full_slots_free: got %h want f", say__RDY); end
      step();
      for (int ch = 0; ch < 4; ch++) begin
         load_call(ch, 32'h400 + 32'(ch), {32'h5000_0000 + 32'(ch), 32'h6000_0000 + 32'(ch)});
         add_exp(ch, 32'h400 + 32'(ch), {32'h5000_0000 + 32'(ch), 32'h6000_0000 + 32'(ch)});
      end
      say__ENA = 4'hF;
      step();
      say__ENA = '0;
      say_meth = '0;
      say_v    = '0;
      repeat (3) step();
      @(negedge CLK);
      n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count_held: got %0d want 4", fifo_count); end
      n_vec++; if (say__RDY !== 4'h0) begin n_err++; $display("FAIL full_slots_held: got %h want 0", say__RDY); end
      n_vec++; if (pipe_enq__ENA !== 1'b1) begin n_err++; $display("FAIL full_pipe_ena: got %b want 1", pipe_enq__ENA); end
      n_vec++; if (pipe_enq_v !== 32'h0000_0002) begin n_err++; $display("FAIL full_head_word: got %h want 00000002", pipe_enq_v); end
      step();
      pipe_enq__RDY = 1'b1;
      t = 0;
      while (msg_count !== 32'd8 && t < 300) begin step(); t++; end
      n_vec++; if (msg_count !== 32'd8) begin n_err++; $display("FAIL full_drain: got %0d want 8", msg_count); end
      n_vec++; if (got_q.size() !== 32) begin n_err++; $display("FAIL full_len: got %0d words want 32", got_q.size()); end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_vec++; if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL full_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
      end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL full_empty_after: got %0d want 0", fifo_count); end
   endtask

   task automatic test_stall();
      int t;
      logic prev_ena, prev_rdy;
      logic [31:0] prev_word;
      do_reset();
      pipe_enq__RDY = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         load_call(ch, 32'h500 + 32'(ch), {32'h7700_0000 + 32'(ch), 32'h8800_0000 + 32'(ch)});
         add_exp(ch, 32'h500 + 32'(ch), {32'h7700_0000 + 32'(ch), 32'h8800_0000 + 32'(ch)});
      end
      say__ENA = 4'b0111;
      step();
      say__ENA = '0;
      prev_ena  = 1'b0;
      prev_rdy  = 1'b1;
      prev_word = '0;
      for (int i = 0; i < 60; i++) begin
         pipe_enq__RDY = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (prev_ena && !prev_rdy) begin
            n_vec++;
            if (pipe_enq_v !== prev_word || pipe_enq__ENA !== 1'b1) begin
               n_err++;
               $display("FAIL stall_hold cycle %0d: got %h ena %b want %h ena 1", i, pipe_enq_v, pipe_enq__ENA, prev_word);
            end
         end
         prev_ena  = pipe_enq__ENA;
         prev_rdy  = pipe_enq__RDY;
         prev_word = pipe_enq_v;
         step();
      end
      pipe_enq__RDY = 1'b1;
      t = 0;
      while (msg_count !== 32'd3 && t < 200) begin step(); t++; end
      n_vec++; if (msg_count !== 32'd3) begin n_err++; $display("FAIL stall_drain: got %0d want 3", msg_count); end
      n_vec++; if (got_q.size() !== 12) begin n_err++; $display("FAIL stall_len: got %0d words want 12", got_q.size()); end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_vec++; if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL stall_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_reset_mid();
      int t;
      do_reset();
      pipe_enq__RDY = 1'b1;
      load_call(1, 32'h601, 64'h0101_0101_0202_0202);
      load_call(3, 32'h603, 64'h0303_0303_0404_0404);
      say__ENA = 4'b1010;
      step();
      say__ENA = '0;
      t = 0;
      while (got_q.size() < 3 && t < 50) begin step(); t++; end
      n_vec++; if (got_q.size() !== 3) begin n_err++; $display("FAIL mid_reach_word2: got %0d words want 3", got_q.size()); end
      nRST = 1'b1;
      @(negedge CLK);
      n_vec++; if (pipe_enq__ENA !== 1'b0) begin n_err++; $display("FAIL mid_rst_ena: got %b want 0", pipe_enq__ENA); end
      n_vec++; if (say__RDY !== 4'h0) begin n_err++; $display("FAIL mid_rst_rdy: got %h want 0", say__RDY); end
      step();
      @(negedge CLK);
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
      n_vec++; if (pipe_enq__ENA !== 1'b0) begin n_err++; $display("FAIL mid_rst_ena2: got %b want 0", pipe_enq__ENA); end
      step();
      nRST = 1'b0;
      @(negedge CLK);
      n_vec++; if (say__RDY !== 4'hF) begin n_err++; $display("FAIL mid_release_rdy: got %h want f", say__RDY); end
      repeat (20) step();
      n_vec++; if (got_q.size() !== 3) begin n_err++; $display("FAIL mid_stale_words: got %0d words want 3", got_q.size()); end
      n_vec++; if (msg_count !== 32'd0) begin n_err++; $display("FAIL mid_msg_count: got %0d want 0", msg_count); end
   endtask

   task automatic test_width();
      logic [31:0] ea [3];
      logic [31:0] eb [6];
      ea = '{32'h0000_0001, 32'h0000_0077, 32'hDEAD_BEEF};
      eb = '{32'h0000_0004, 32'h0000_0088, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      do_reset();
      a_prdy = 1'b1;
      b_prdy = 1'b1;
      @(negedge CLK);
      n_vec++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin n_err++; $display("FAIL width_rdy: got %b%b want 11", a_rdy, b_rdy); end
      step();
      a_meth = 32'h77;
      a_v    = 32'hDEAD_BEEF;
      b_meth = 32'h88;
      b_v    = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      a_ena  = 1'b1;
      b_ena  = 1'b1;
      step();
      a_ena = 1'b0;
      b_ena = 1'b0;
      repeat (15) step();
      n_vec++; if (got_a_q.size() !== 3) begin n_err++; $display("FAIL width32_len: got %0d want 3", got_a_q.size()); end
      n_vec++; if (got_b_q.size() !== 6) begin n_err++; $display("FAIL width128_len: got %0d want 6", got_b_q.size()); end
      for (int j = 0; j < 3 && j < got_a_q.size(); j++) begin
         n_vec++; if (got_a_q[j] !== ea[j]) begin n_err++; $display("FAIL width32_word%0d: got %h want %h", j, got_a_q[j], ea[j]); end
      end
      for (int j = 0; j < 6 && j < got_b_q.size(); j++) begin
         n_vec++; if (got_b_q[j] !== eb[j]) begin n_err++; $display("FAIL width128_word%0d: got %h want %h", j, got_b_q[j], eb[j]); end
      end
      n_vec++; if (a_mcnt !== 32'd1 || b_mcnt !== 32'd1) begin n_err++; $display("FAIL width_msg_count: got %0d/%0d want 1/1", a_mcnt, b_mcnt); end
      n_vec++; if (a_fcnt !== 3'd0 || b_fcnt !== 3'd0) begin n_err++; $display("FAIL width_fifo_count: got %0d/%0d want 0/0", a_fcnt, b_fcnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_stall();
      test_reset_mid();
      test_width();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
